// File: rtl/btcminer_pkg.sv
// ============================================================================
// btcminer_pkg : shared widths and helpers for the miner result path.
// Rev 1.0
// ============================================================================
`default_nettype none

package btcminer_pkg;

  localparam int RESULT_W       = 96;
  localparam int STATUS_OVF_BIT = 7;
  localparam int OUT_BYTES      = 13;
  localparam int OBUF_W         = OUT_BYTES * 8;

  // Status byte carries a 7-bit entry count; deeper FIFOs report 127.
  function automatic logic [6:0] sat_count7(input int unsigned n);
    return (n > 32'd127) ? 7'd127 : n[6:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/result_fifo.sv
// ============================================================================
// result_fifo : DEPTH x W synchronous FIFO with combinational head read.
// Rev 1.0
// ============================================================================
`default_nettype none

module result_fifo
  import btcminer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = RESULT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/golden_nonce_fifo.sv
// ============================================================================
// golden_nonce_fifo : queues golden-nonce hits and serializes them to the host.
// Rev 1.0
// ============================================================================
`default_nettype none

module golden_nonce_fifo
  import btcminer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] golden_nonce,
  input  logic [31:0] nonce2,
  input  logic [31:0] hash2,
  input  logic        wr_start,
  input  logic        wr_clk,
  output logic [7:0]  write,
  output logic [AW:0] count,
  output logic        overflow
);

  logic [31:0]         last_golden_q, last_golden_d;
  logic                s1_q, s2_q, s3_q;
  logic                w1_q, w2_q;
  logic [OBUF_W-1:0]   obuf_q, obuf_d;
  logic                overflow_q, overflow_d;

  logic                push_req, load, shift, drop;
  logic                fifo_full, fifo_empty;
  logic [RESULT_W-1:0] head, load_data;
  logic [7:0]          status;

  assign push_req = (golden_nonce != last_golden_q);
  assign load     = s2_q & ~s3_q;
  assign shift    = (w1_q ^ w2_q) & ~s2_q;
  // A load at full always frees a slot, so only a load-free edge can drop.
  assign drop     = push_req & fifo_full & ~load;

  result_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (RESULT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (load),
    .din   ({hash2, nonce2, golden_nonce}),
    .dout  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status                 = {1'b0, sat_count7(32'(count))};
    status[STATUS_OVF_BIT] = overflow_q;
    load_data              = fifo_empty ? {RESULT_W{1'b0}} : head;
  end

  always_comb begin
    last_golden_d = last_golden_q;
    overflow_d    = overflow_q;
    obuf_d        = obuf_q;
    if (push_req) last_golden_d = golden_nonce;
    if (load) begin
      obuf_d     = {load_data, status};
      overflow_d = 1'b0;
    end else if (shift) begin
      // Top byte is retained so extra host clocks keep presenting it.
      obuf_d = {obuf_q[OBUF_W-1 -: 8], obuf_q[OBUF_W-1:8]};
    end
    if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_golden_q <= '0;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      w1_q          <= 1'b0;
      w2_q          <= 1'b0;
      obuf_q        <= '0;
      overflow_q    <= 1'b0;
    end else begin
      last_golden_q <= last_golden_d;
      s1_q          <= wr_start;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      w1_q          <= wr_clk;
      w2_q          <= w1_q;
      obuf_q        <= obuf_d;
      overflow_q    <= overflow_d;
    end
  end

  assign write    = obuf_q[7:0];
  assign overflow = overflow_q;

endmodule

`default_nettype wire
